// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared constants for the sequential BCD-to-binary converter: default sizes,
// the digit width and the two-state FSM encoding.
package bcd_to_bin_seq_pkg;

    localparam int DIGITS_DEFAULT = 3;
    localparam int BIN_W_DEFAULT  = 10;
    localparam int DIGIT_W        = 4;

    localparam int STATE_W = 1;
    localparam logic [STATE_W-1:0] ST_IDLE  = 1'b0;
    localparam logic [STATE_W-1:0] ST_SHIFT = 1'b1;

    // Largest legal value of a single BCD digit.
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd_to_bin_seq_digit_sub3.sv
// One BCD digit correction for the reverse double-dabble step:
// a digit that reads 8 or more after the right shift is reduced by 3.
module bcd_digit_sub3
    import bcd_to_bin_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);

    assign q = (d >= 4'd8) ? (d - 4'd3) : d;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter using reverse double-dabble:
// one right shift plus per-digit correction per clock, BIN_W clocks per result.
module bcd_to_bin_seq
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEFAULT,
    parameter int BIN_W  = BIN_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic [BIN_W-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int BCD_W  = DIGIT_W * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    // Request semantics: start is sampled on every rising edge but only acts
    // in IDLE; while busy it is dropped without queueing. done pulses for one
    // cycle with bin/err updated, and start in that cycle is taken normally.
    // Because there are only two states, busy is the FSM state made visible.

    logic [STATE_W-1:0] state;
    logic [BCD_W-1:0]   bcd_r;
    logic [BIN_W-1:0]   bin_r;
    logic [CNT_W-1:0]   cnt;

    logic [WORK_W-1:0]  shifted;
    logic [BCD_W-1:0]   bcd_next;
    logic [BIN_W-1:0]   bin_next;
    logic               bcd_bad;

    assign shifted  = {bcd_r, bin_r} >> 1;
    assign bin_next = shifted[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_sub3 u_sub3 (
            .d (shifted[BIN_W + g*DIGIT_W +: DIGIT_W]),
            .q (bcd_next[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_comb begin
        bcd_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*DIGIT_W +: DIGIT_W] > DIGIT_MAX) begin
                bcd_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            bcd_r <= '0;
            bin_r <= '0;
            cnt   <= '0;
            bin   <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (bcd_bad) begin
                            // Rejected operand: report immediately, never go busy.
                            bin  <= '0;
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            bcd_r <= bcd;
                            bin_r <= '0;
                            cnt   <= '0;
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    bcd_r <= bcd_next;
                    bin_r <= bin_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        bin   <= bin_next;
                        err   <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: directed cases plus randomized
// requests checked against a decimal-arithmetic reference model.
module tb_bcd_to_bin_seq;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;
    localparam int BCD_W  = 4 * DIGITS;

    logic             clk;
    logic             rst;
    logic             start;
    logic [BCD_W-1:0] bcd;
    logic [BIN_W-1:0] bin;
    logic             busy;
    logic             done;
    logic             err;

    int n_checks;
    int n_fail;
    int n_reqs;
    int done_seen;
    logic [BIN_W-1:0] last_bin;
    logic             last_err;
    logic [BIN_W-1:0] exp_q[$];

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bcd   (bcd),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: decimal weighting of each nibble.
    function automatic void ref_model(input logic [BCD_W-1:0] v, output bit bad, output int value);
        int weight;
        int digit;
        bad    = 1'b0;
        value  = 0;
        weight = 1;
        for (int i = 0; i < DIGITS; i++) begin
            digit = int'((v >> (4 * i)) & 12'hF);
            if (digit > 9) bad = 1'b1;
            value  = value + digit * weight;
            weight = weight * 10;
        end
    endfunction

    function automatic logic [BCD_W-1:0] rand_valid_bcd();
        logic [BCD_W-1:0] v;
        v = '0;
        for (int i = 0; i < DIGITS; i++) begin
            v = v | (BCD_W'($urandom_range(0, 9)) << (4 * i));
        end
        return v;
    endfunction

    // Driver: called at a negedge with the DUT idle (or in its done cycle).
    // ignore_at >= 0 issues a stray start during that busy cycle.
    task automatic convert(input logic [BCD_W-1:0] val, input int ignore_at,
                           input logic [BCD_W-1:0] ign_val);
        bit bad;
        int value;
        ref_model(val, bad, value);
        n_reqs++;
        start = 1'b1;
        bcd   = val;
        @(negedge clk);
        start = 1'b0;
        bcd   = BCD_W'($urandom);
        if (bad) begin
            check("inv_done", done, 1);
            check("inv_err", err, 1);
            check("inv_bin", bin, 0);
            check("inv_busy", busy, 0);
            last_bin = '0;
            last_err = 1'b1;
            return;
        end
        exp_q.push_back(BIN_W'(value));
        for (int i = 0; i < BIN_W; i++) begin
            check("busy", busy, 1);
            check("no_done", done, 0);
            check("hold_bin", bin, last_bin);
            check("hold_err", err, last_err);
            if (i == ignore_at) begin
                start = 1'b1;
                bcd   = ign_val;
            end else begin
                start = 1'b0;
                bcd   = BCD_W'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done", done, 1);
        check("busy_end", busy, 0);
        check("err_clr", err, 0);
        if (exp_q.size() == 0) begin
            check("queue_empty", 1, 0);
        end else begin
            check("bin", bin, exp_q.pop_front());
        end
        last_bin = bin;
        last_err = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            check("idle_busy", busy, 0);
            @(negedge clk);
            check("idle_done", done, 0);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        n_reqs    = 0;
        done_seen = 0;
        last_bin  = '0;
        last_err  = 1'b0;
        rst   = 1'b1;
        start = 1'b0;
        bcd   = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_bin", bin, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        idle_cycles(2);

        convert(12'h255, -1, '0);
        idle_cycles(1);
        convert(12'h999, -1, '0);
        convert(12'h000, -1, '0);
        idle_cycles(2);
        convert(12'h1A3, -1, '0);
        idle_cycles(2);
        convert(12'h059, 3, 12'h777);
        idle_cycles(1);

        // Reset in the middle of a conversion aborts it silently.
        start = 1'b1;
        bcd   = 12'h123;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_bin", bin, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        last_bin = '0;
        last_err = 1'b0;
        idle_cycles(3);
        convert(12'h042, -1, '0);
        // back-to-back: next start driven in the done cycle
        convert(12'h698, -1, '0);
        convert(12'hF00, -1, '0);
        convert(12'h007, -1, '0);

        for (int t = 0; t < 40; t++) begin
            logic [BCD_W-1:0] v;
            int ign;
            if ($urandom_range(0, 7) == 0) v = BCD_W'($urandom);
            else v = rand_valid_bcd();
            ign = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, BIN_W - 1)) : -1;
            convert(v, ign, BCD_W'($urandom));
            if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
        end

        idle_cycles(2);
        check("done_count", done_seen, n_reqs);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
